// File: rtl/baccarat_pkg.sv
// Shared baccarat types and rules: FSM states, rank limits, card values and the banker third-card table.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_P1, S_D1, S_P2, S_D2, S_CHK2, S_P3, S_CHK3, S_D3, S_RESULT, S_DONE
  } state_t;

  localparam logic [3:0] RANK_MIN = 4'd1;
  localparam logic [3:0] RANK_MAX = 4'd13;

  // Rank 0 (empty slot) and court/ten cards are worth nothing.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank <= 4'd9) ? rank : 4'd0;
  endfunction

  function automatic logic rank_valid(input logic [3:0] rank);
    return (rank >= RANK_MIN) && (rank <= RANK_MAX);
  endfunction

  // b = banker two-card score, v = value of the player's third card.
  function automatic logic banker_draws(input logic [3:0] b, input logic [3:0] v);
    logic r;
    case (b)
      4'd0, 4'd1, 4'd2: r = 1'b1;
      4'd3:             r = (v != 4'd8);
      4'd4:             r = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             r = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             r = (v >= 4'd6) && (v <= 4'd7);
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hand_score.sv
// Combinational baccarat hand score: sum of three card values modulo 10.
module hand_score
  import baccarat_pkg::*;
(
  input  logic [3:0] i_rank1,
  input  logic [3:0] i_rank2,
  input  logic [3:0] i_rank3,
  output logic [3:0] o_score
);

  logic [4:0] w_sum;

  assign w_sum = {1'b0, card_value(i_rank1)} + {1'b0, card_value(i_rank2)}
               + {1'b0, card_value(i_rank3)};

  always_comb begin
    if (w_sum >= 5'd20)      o_score = 4'(w_sum - 5'd20);
    else if (w_sum >= 5'd10) o_score = 4'(w_sum - 5'd10);
    else                     o_score = 4'(w_sum);
  end

endmodule

// File: rtl/baccarat_round_ctrl.sv
// Baccarat round sequencer: deals six slots over a valid/ready card feed, applies natural and
// third-card rules, drives the win lights and keeps saturating session tallies.
module baccarat_round_ctrl
  import baccarat_pkg::*;
#(
  parameter int unsigned TALLY_W   = 8,
  parameter bit          AUTO_DEAL = 1'b0
) (
  input  logic               slow_clock,
  input  logic               reset,
  input  logic               new_round,
  input  logic               card_valid,
  input  logic [3:0]         card_rank,
  output logic               card_ready,
  output logic [3:0]         pcard1,
  output logic [3:0]         pcard2,
  output logic [3:0]         pcard3,
  output logic [3:0]         dcard1,
  output logic [3:0]         dcard2,
  output logic [3:0]         dcard3,
  output logic [3:0]         pscore,
  output logic [3:0]         dscore,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               busy,
  output logic               round_done,
  output logic [TALLY_W-1:0] player_wins,
  output logic [TALLY_W-1:0] dealer_wins,
  output logic [TALLY_W-1:0] ties
);

  state_t r_state, w_state_n;
  logic   w_load, w_clear, w_result;
  logic [3:0] r_pcard1, r_pcard2, r_pcard3, r_dcard1, r_dcard2, r_dcard3;
  logic [3:0] r_pscore, r_dscore, w_pscore, w_dscore;
  logic       r_player_light, r_dealer_light, r_round_done;
  logic [TALLY_W-1:0] r_player_wins, r_dealer_wins, r_ties;

  hand_score u_player (
    .i_rank1(r_pcard1), .i_rank2(r_pcard2), .i_rank3(r_pcard3), .o_score(w_pscore)
  );
  hand_score u_dealer (
    .i_rank1(r_dcard1), .i_rank2(r_dcard2), .i_rank3(r_dcard3), .o_score(w_dscore)
  );

  always_ff @(posedge slow_clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  // Decisions read the slot-derived scores so the card loaded on the previous edge already counts;
  // the registered score outputs show the same value one cycle later.
  always_comb begin
    w_state_n  = r_state;
    card_ready = 1'b0;
    w_load     = 1'b0;
    w_clear    = 1'b0;
    w_result   = 1'b0;
    busy       = !((r_state == S_IDLE) || (r_state == S_DONE));
    case (r_state)
      S_IDLE: begin
        if (new_round) begin
          w_state_n = S_P1;
          w_clear   = 1'b1;
        end
      end
      S_P1, S_D1, S_P2, S_D2, S_P3, S_D3: begin
        card_ready = 1'b1;
        if (card_valid && rank_valid(card_rank)) begin
          w_load = 1'b1;
          case (r_state)
            S_P1:    w_state_n = S_D1;
            S_D1:    w_state_n = S_P2;
            S_P2:    w_state_n = S_D2;
            S_D2:    w_state_n = S_CHK2;
            S_P3:    w_state_n = S_CHK3;
            default: w_state_n = S_RESULT;
          endcase
        end
      end
      S_CHK2: begin
        if ((w_pscore >= 4'd8) || (w_dscore >= 4'd8)) w_state_n = S_RESULT;
        else if (w_pscore <= 4'd5)                     w_state_n = S_P3;
        else if (w_dscore <= 4'd5)                     w_state_n = S_D3;
        else                                           w_state_n = S_RESULT;
      end
      S_CHK3: begin
        if (banker_draws(w_dscore, card_value(r_pcard3))) w_state_n = S_D3;
        else                                              w_state_n = S_RESULT;
      end
      S_RESULT: begin
        w_result  = 1'b1;
        w_state_n = S_DONE;
      end
      S_DONE: begin
        if (new_round || AUTO_DEAL) begin
          w_state_n = S_P1;
          w_clear   = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (reset || w_clear) begin
      r_pcard1       <= '0;
      r_pcard2       <= '0;
      r_pcard3       <= '0;
      r_dcard1       <= '0;
      r_dcard2       <= '0;
      r_dcard3       <= '0;
      r_pscore       <= '0;
      r_dscore       <= '0;
      r_player_light <= 1'b0;
      r_dealer_light <= 1'b0;
    end else begin
      if (w_load) begin
        case (r_state)
          S_P1:    r_pcard1 <= card_rank;
          S_D1:    r_dcard1 <= card_rank;
          S_P2:    r_pcard2 <= card_rank;
          S_D2:    r_dcard2 <= card_rank;
          S_P3:    r_pcard3 <= card_rank;
          S_D3:    r_dcard3 <= card_rank;
          default: ;
        endcase
      end
      r_pscore <= w_pscore;
      r_dscore <= w_dscore;
      if (w_result) begin
        r_player_light <= (w_pscore >= w_dscore);
        r_dealer_light <= (w_dscore >= w_pscore);
      end
    end
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      r_round_done  <= 1'b0;
      r_player_wins <= '0;
      r_dealer_wins <= '0;
      r_ties        <= '0;
    end else begin
      r_round_done <= w_result;
      if (w_result) begin
        if (w_pscore > w_dscore) begin
          if (r_player_wins != '1) r_player_wins <= r_player_wins + TALLY_W'(1);
        end else if (w_pscore < w_dscore) begin
          if (r_dealer_wins != '1) r_dealer_wins <= r_dealer_wins + TALLY_W'(1);
        end else begin
          if (r_ties != '1) r_ties <= r_ties + TALLY_W'(1);
        end
      end
    end
  end

  assign pcard1           = r_pcard1;
  assign pcard2           = r_pcard2;
  assign pcard3           = r_pcard3;
  assign dcard1           = r_dcard1;
  assign dcard2           = r_dcard2;
  assign dcard3           = r_dcard3;
  assign pscore           = r_pscore;
  assign dscore           = r_dscore;
  assign player_win_light = r_player_light;
  assign dealer_win_light = r_dealer_light;
  assign round_done       = r_round_done;
  assign player_wins      = r_player_wins;
  assign dealer_wins      = r_dealer_wins;
  assign ties             = r_ties;

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Scoreboard bench for baccarat_round_ctrl: a rules-level round model predicts each round's final
// table; a monitor compares it whenever round_done pulses.
module tb_baccarat_round_ctrl;

  localparam int unsigned TW = 2;
  localparam int TALLY_MAX = (1 << TW) - 1;
  // Banker draws when bit v is set in the mask for two-card score b (b >= 8 never reaches here).
  localparam logic [9:0] BANK_MASK [8] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF,
                                           10'h0FC, 10'h0F0, 10'h0C0, 10'h000};

  logic slow_clock = 1'b0;
  logic reset = 1'b1, new_round = 1'b0, card_valid = 1'b0;
  logic [3:0] card_rank = 4'd0;
  logic card_ready, player_win_light, dealer_win_light, busy, round_done;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
  logic [TW-1:0] player_wins, dealer_wins, ties;

  baccarat_round_ctrl #(.TALLY_W(TW), .AUTO_DEAL(1'b0)) dut (
    .slow_clock(slow_clock), .reset(reset), .new_round(new_round),
    .card_valid(card_valid), .card_rank(card_rank), .card_ready(card_ready),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore),
    .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
    .busy(busy), .round_done(round_done),
    .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties)
  );

  always #5 slow_clock = ~slow_clock;

  typedef struct {
    int p1, p2, p3, d1, d2, d3, ps, ds;
    bit pl, dl;
    int pw, dw, ti;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int errors = 0, checks = 0, rounds_seen = 0;
  int m_pw = 0, m_dw = 0, m_ti = 0;

  function automatic int val(input int r);
    return (r >= 1 && r <= 9) ? r : 0;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Plays the round by the table rules from cards c[] in deal order; n = cards actually drawn.
  task automatic predict(input int c[6], output exp_t e, output int n);
    int p, d, v;
    bit bdraw;
    e.p1 = c[0]; e.d1 = c[1]; e.p2 = c[2]; e.d2 = c[3]; e.p3 = 0; e.d3 = 0;
    n = 4;
    p = (val(c[0]) + val(c[2])) % 10;
    d = (val(c[1]) + val(c[3])) % 10;
    if (p < 8 && d < 8) begin
      if (p <= 5) begin
        e.p3 = c[n]; v = val(c[n]); n++;
        bdraw = BANK_MASK[d][v];
      end else begin
        bdraw = (d <= 5);
      end
      if (bdraw) begin e.d3 = c[n]; n++; end
    end
    e.ps = (val(e.p1) + val(e.p2) + val(e.p3)) % 10;
    e.ds = (val(e.d1) + val(e.d2) + val(e.d3)) % 10;
    e.pl = (e.ps >= e.ds);
    e.dl = (e.ds >= e.ps);
    if (e.ps > e.ds)      begin if (m_pw < TALLY_MAX) m_pw++; end
    else if (e.ps < e.ds) begin if (m_dw < TALLY_MAX) m_dw++; end
    else                  begin if (m_ti < TALLY_MAX) m_ti++; end
    e.pw = m_pw; e.dw = m_dw; e.ti = m_ti;
  endtask

  always @(negedge slow_clock) begin
    if (!reset && round_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_round_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pcard1", int'(pcard1), mon_e.p1);
        chk("pcard2", int'(pcard2), mon_e.p2);
        chk("pcard3", int'(pcard3), mon_e.p3);
        chk("dcard1", int'(dcard1), mon_e.d1);
        chk("dcard2", int'(dcard2), mon_e.d2);
        chk("dcard3", int'(dcard3), mon_e.d3);
        chk("pscore", int'(pscore), mon_e.ps);
        chk("dscore", int'(dscore), mon_e.ds);
        chk("player_light", int'(player_win_light), int'(mon_e.pl));
        chk("dealer_light", int'(dealer_win_light), int'(mon_e.dl));
        chk("player_wins", int'(player_wins), mon_e.pw);
        chk("dealer_wins", int'(dealer_wins), mon_e.dw);
        chk("ties", int'(ties), mon_e.ti);
      end
      rounds_seen++;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_slots_scores"},
        int'({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore}), 0);
    chk({tag, "_ctrl_tallies"},
        int'({card_ready, busy, round_done, player_win_light, dealer_win_light,
              player_wins, dealer_wins, ties}), 0);
  endtask

  task automatic pulse_new_round();
    new_round = 1'b1;
    @(negedge slow_clock);
    new_round = 1'b0;
  endtask

  // Called at a negedge; presents r until accepted, returns at a later negedge.
  task automatic send_card(input int r);
    int  k = 0;
    bit  got = 1'b0;
    card_valid = 1'b1;
    card_rank  = 4'(r);
    while (!got && k < 50) begin
      if (card_ready) begin
        @(posedge slow_clock);
        #1;
        got = 1'b1;
      end else begin
        @(negedge slow_clock);
        k++;
      end
    end
    card_valid = 1'b0;
    card_rank  = 4'd0;
    if (!got) chk("card_accept_timeout", 0, 1);
    @(negedge slow_clock);
  endtask

  // inj: 0 none, 1 rank 14 before the first card, 2 random invalid ranks.
  task automatic run_round(input int c[6], input int inj, input bit poke, input int maxgap);
    exp_t e;
    int n, target, k, inv;
    predict(c, e, n);
    exp_q.push_back(e);
    target = rounds_seen + 1;
    pulse_new_round();
    for (int i = 0; i < n; i++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge slow_clock);
      if (poke && i == 2) pulse_new_round();
      if ((inj == 1 && i == 0) || (inj == 2 && $urandom_range(0, 4) == 0)) begin
        inv = (inj == 1) ? 14 : int'($urandom_range(0, 2));
        send_card((inv == 0 || inv == 14) ? inv : 13 + inv);
      end
      send_card(c[i]);
    end
    k = 0;
    while (rounds_seen < target && k < 20) begin
      @(negedge slow_clock);
      k++;
    end
    chk("round_completed", int'(rounds_seen >= target), 1);
    @(negedge slow_clock);
    chk("round_done_one_cycle", int'(round_done), 0);
    chk("done_card_ready", int'(card_ready), 0);
    chk("done_busy", int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int c[6];
    repeat (3) @(negedge slow_clock);
    reset = 1'b0;
    check_zero("after_reset");

    // Abort in D2 with a card on offer; reset wins.
    pulse_new_round();
    send_card(1);
    send_card(2);
    send_card(3);
    chk("in_d2_ready", int'(card_ready), 1);
    card_valid = 1'b1;
    card_rank  = 4'd4;
    reset      = 1'b1;
    @(posedge slow_clock);
    #1;
    check_zero("reset_mid_d2");
    @(negedge slow_clock);
    reset = 1'b0;
    @(negedge slow_clock);
    chk("idle_ignores_card_ready", int'(card_ready), 0);
    chk("idle_ignores_card_slot", int'(pcard1), 0);
    card_valid = 1'b0;
    card_rank  = 4'd0;

    c = '{8, 5, 13, 5, 1, 1};  run_round(c, 0, 1'b0, 0);
    c = '{2, 10, 3, 4, 7, 2};  run_round(c, 0, 1'b0, 0);
    c = '{2, 3, 3, 3, 8, 1};   run_round(c, 0, 1'b0, 0);
    c = '{6, 4, 13, 3, 1, 1};  run_round(c, 1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      c = '{8, 5, 13, 5, 1, 1};
      run_round(c, 0, 1'b1, 1);
    end
    chk("player_wins_saturated", int'(player_wins), 3);

    for (int r = 0; r < 40; r++) begin
      for (int j = 0; j < 6; j++) c[j] = int'($urandom_range(1, 13));
      run_round(c, 2, 1'($urandom_range(0, 1)), 2);
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
